// File: rtl/id_stage_if.sv
// Bundles the IF-side, write-back and ID/EX signals of the decode stage.
// No logic of its own; id_stage drives the ID/EX side through the slave view.
// Back-pressure travels as ex_hold (in) and id_stall (out).
interface id_stage_if #(
   parameter int XLEN = 64
);
   logic            if_valid;
   logic [31:0]     if_inst;
   logic [XLEN-1:0] if_pc;
   logic            ex_hold;
   logic            flush;
   logic            wb_we;
   logic [4:0]      wb_rd;
   logic [XLEN-1:0] wb_data;
   logic            id_stall;
   logic            ex_valid;
   logic [XLEN-1:0] ex_pc;
   logic [XLEN-1:0] ex_rs1_data;
   logic [XLEN-1:0] ex_rs2_data;
   logic [XLEN-1:0] ex_imm;
   logic [4:0]      ex_rs1;
   logic [4:0]      ex_rs2;
   logic [4:0]      ex_rd;
   logic [2:0]      ex_funct3;
   logic [6:0]      ex_funct7;
   logic            ex_branch;
   logic            ex_memread;
   logic            ex_memwrite;
   logic            ex_memtoreg;
   logic            ex_alusrc;
   logic            ex_regwrite;
   logic [1:0]      ex_aluop;
   logic            ex_illegal;

   modport master (
      output if_valid, if_inst, if_pc, ex_hold, flush, wb_we, wb_rd, wb_data,
      input  id_stall, ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
             ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7, ex_branch, ex_memread,
             ex_memwrite, ex_memtoreg, ex_alusrc, ex_regwrite, ex_aluop, ex_illegal
   );

   modport slave (
      input  if_valid, if_inst, if_pc, ex_hold, flush, wb_we, wb_rd, wb_data,
      output id_stall, ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
             ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7, ex_branch, ex_memread,
             ex_memwrite, ex_memtoreg, ex_alusrc, ex_regwrite, ex_aluop, ex_illegal
   );
endinterface

// File: rtl/id_stage.sv
// Instruction decode: field split, register file with WB bypass, immediates, control, load-use detect.
// One cycle: the instruction presented in ID appears on the registered ID/EX outputs after the next edge.
// ex_hold freezes ID/EX and raises id_stall; a load-use hazard inserts one bubble; flush overrides both.
module id_stage #(
   parameter int XLEN   = 64,
   parameter int NREG   = 32,
   parameter int BYPASS = 1
) (
   input  logic      clk,
   input  logic      reset,
   id_stage_if.slave bus
);
   localparam int AW   = $clog2(NREG);
   localparam bit IS64 = (XLEN == 64);
   localparam bit RV16 = (NREG == 16);

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_RW     = 7'b0111011;
   localparam logic [6:0] OP_IW     = 7'b0011011;

   typedef struct packed {
      logic       branch;
      logic       memread;
      logic       memwrite;
      logic       memtoreg;
      logic       alusrc;
      logic       regwrite;
      logic [1:0] aluop;
      logic       illegal;
   } ctrl_t;

   logic [31:0] inst;
   logic [6:0]  opcode;
   logic [4:0]  rs1, rs2, rd;

   assign inst   = bus.if_inst;
   assign opcode = inst[6:0];
   assign rd     = inst[11:7];
   assign rs1    = inst[19:15];
   assign rs2    = inst[24:20];

   logic [31:0]     imm_i, imm_s, imm_b, imm_u, imm_j, imm32;
   logic [XLEN-1:0] imm;

   assign imm_i = {{20{inst[31]}}, inst[31:20]};
   assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
   assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
   assign imm_u = {inst[31:12], 12'b0};
   assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
   assign imm   = XLEN'($signed(imm32));

   ctrl_t dec;
   logic  use_rs1, use_rs2, use_rd;

   // Opcode decode: controls, immediate format and which register indices the instruction uses.
   always_comb begin
      dec     = '0;
      imm32   = '0;
      use_rs1 = 1'b1;
      use_rs2 = 1'b0;
      use_rd  = 1'b0;
      case (opcode)
         OP_R: begin
            dec.regwrite = 1'b1; dec.aluop = 2'b10; use_rs2 = 1'b1; use_rd = 1'b1;
         end
         OP_I: begin
            dec.alusrc = 1'b1; dec.regwrite = 1'b1; dec.aluop = 2'b10;
            imm32 = imm_i; use_rd = 1'b1;
         end
         OP_LOAD: begin
            dec.memread = 1'b1; dec.memtoreg = 1'b1; dec.alusrc = 1'b1; dec.regwrite = 1'b1;
            imm32 = imm_i; use_rd = 1'b1;
         end
         OP_STORE: begin
            dec.memwrite = 1'b1; dec.alusrc = 1'b1; imm32 = imm_s; use_rs2 = 1'b1;
         end
         OP_BRANCH: begin
            dec.branch = 1'b1; dec.aluop = 2'b01; imm32 = imm_b; use_rs2 = 1'b1;
         end
         OP_LUI, OP_AUIPC: begin
            dec.regwrite = 1'b1; dec.alusrc = 1'b1; dec.aluop = 2'b11;
            imm32 = imm_u; use_rs1 = 1'b0; use_rd = 1'b1;
         end
         OP_JAL: begin
            dec.regwrite = 1'b1; dec.alusrc = 1'b1; dec.aluop = 2'b11;
            imm32 = imm_j; use_rs1 = 1'b0; use_rd = 1'b1;
         end
         OP_JALR: begin
            dec.regwrite = 1'b1; dec.alusrc = 1'b1; dec.aluop = 2'b11;
            imm32 = imm_i; use_rd = 1'b1;
         end
         OP_RW: begin
            use_rs2 = 1'b1; use_rd = 1'b1;
            if (IS64) begin
               dec.regwrite = 1'b1; dec.aluop = 2'b10;
            end else begin
               dec.illegal = 1'b1;
            end
         end
         OP_IW: begin
            imm32 = imm_i; use_rd = 1'b1;
            if (IS64) begin
               dec.alusrc = 1'b1; dec.regwrite = 1'b1; dec.aluop = 2'b10;
            end else begin
               dec.illegal = 1'b1;
            end
         end
         default: dec.illegal = 1'b1;
      endcase
      // 16-register cores have no x16..x31; touching one is an illegal instruction.
      if (RV16 && ((use_rs1 && rs1[4]) || (use_rs2 && rs2[4]) || (use_rd && rd[4]))) begin
         dec         = '0;
         dec.illegal = 1'b1;
      end
   end

   logic [XLEN-1:0] rf [NREG];
   logic [XLEN-1:0] rs1_data, rs2_data;
   logic            wr_ok;

   assign wr_ok = bus.wb_we && (bus.wb_rd != 5'd0) && (!RV16 || !bus.wb_rd[4]);

   // Register read with optional same-cycle forwarding of the write-back value; x0 is hard zero.
   always_comb begin
      rs1_data = '0;
      rs2_data = '0;
      if (rs1 != 5'd0 && (!RV16 || !rs1[4])) begin
         if (BYPASS != 0 && wr_ok && bus.wb_rd == rs1) rs1_data = bus.wb_data;
         else                                          rs1_data = rf[rs1[AW-1:0]];
      end
      if (rs2 != 5'd0 && (!RV16 || !rs2[4])) begin
         if (BYPASS != 0 && wr_ok && bus.wb_rd == rs2) rs2_data = bus.wb_data;
         else                                          rs2_data = rf[rs2[AW-1:0]];
      end
   end

   // Register file write port; index 0 is never written.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREG; i++) rf[i] <= '0;
      end else if (wr_ok) begin
         rf[bus.wb_rd[AW-1:0]] <= bus.wb_data;
      end
   end

   ctrl_t ex_ctl;
   logic  ex_valid_q;
   logic  hazard, capture;

   assign hazard  = bus.if_valid && ex_valid_q && ex_ctl.memread && (bus.ex_rd != 5'd0) &&
                    ((use_rs1 && rs1 == bus.ex_rd) || (use_rs2 && rs2 == bus.ex_rd));
   assign capture = !bus.flush && !bus.ex_hold && !hazard && bus.if_valid;
   assign bus.id_stall = !reset && !bus.flush && (bus.ex_hold || hazard);

   // ID/EX valid and controls: flush clears, hold freezes, otherwise load the decode or a bubble.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ex_valid_q <= 1'b0;
         ex_ctl     <= '0;
      end else if (bus.flush) begin
         ex_valid_q <= 1'b0;
         ex_ctl     <= '0;
      end else if (!bus.ex_hold) begin
         ex_valid_q <= capture;
         ex_ctl     <= capture ? dec : '0;
      end
   end

   // ID/EX operands and indices only change when a real instruction is captured.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bus.ex_pc       <= '0;
         bus.ex_rs1_data <= '0;
         bus.ex_rs2_data <= '0;
         bus.ex_imm      <= '0;
         bus.ex_rs1      <= '0;
         bus.ex_rs2      <= '0;
         bus.ex_rd       <= '0;
         bus.ex_funct3   <= '0;
         bus.ex_funct7   <= '0;
      end else if (capture) begin
         bus.ex_pc       <= bus.if_pc;
         bus.ex_rs1_data <= rs1_data;
         bus.ex_rs2_data <= rs2_data;
         bus.ex_imm      <= imm;
         bus.ex_rs1      <= rs1;
         bus.ex_rs2      <= rs2;
         bus.ex_rd       <= rd;
         bus.ex_funct3   <= inst[14:12];
         bus.ex_funct7   <= inst[31:25];
      end
   end

   assign bus.ex_valid    = ex_valid_q;
   assign bus.ex_branch   = ex_ctl.branch;
   assign bus.ex_memread  = ex_ctl.memread;
   assign bus.ex_memwrite = ex_ctl.memwrite;
   assign bus.ex_memtoreg = ex_ctl.memtoreg;
   assign bus.ex_alusrc   = ex_ctl.alusrc;
   assign bus.ex_regwrite = ex_ctl.regwrite;
   assign bus.ex_aluop    = ex_ctl.aluop;
   assign bus.ex_illegal  = ex_ctl.illegal;
endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: two configurations (64/32/bypass and 32/16/no-bypass) share one stimulus stream.
// A per-cycle reference model predicts ID/EX contents and id_stall; literal checks pin key cases.
// Stimulus is driven on the falling edge, outputs are sampled away from the rising edge.
module tb_id_stage;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        s_valid, s_hold, s_flush, s_we;
   logic [31:0] s_inst;
   logic [63:0] s_pc, s_wdata;
   logic [4:0]  s_wrd;

   int errors = 0;
   int checks = 0;

   id_stage_if #(.XLEN(64)) ba();
   id_stage_if #(.XLEN(32)) bb();

   assign ba.if_valid = s_valid;  assign bb.if_valid = s_valid;
   assign ba.if_inst  = s_inst;   assign bb.if_inst  = s_inst;
   assign ba.if_pc    = s_pc;     assign bb.if_pc    = s_pc[31:0];
   assign ba.ex_hold  = s_hold;   assign bb.ex_hold  = s_hold;
   assign ba.flush    = s_flush;  assign bb.flush    = s_flush;
   assign ba.wb_we    = s_we;     assign bb.wb_we    = s_we;
   assign ba.wb_rd    = s_wrd;    assign bb.wb_rd    = s_wrd;
   assign ba.wb_data  = s_wdata;  assign bb.wb_data  = s_wdata[31:0];

   id_stage #(.XLEN(64), .NREG(32), .BYPASS(1)) dut_a (.clk(clk), .reset(reset), .bus(ba));
   id_stage #(.XLEN(32), .NREG(16), .BYPASS(0)) dut_b (.clk(clk), .reset(reset), .bus(bb));

   typedef struct packed {
      logic       branch, memread, memwrite, memtoreg, alusrc, regwrite;
      logic [1:0] aluop;
      logic       illegal;
   } tctl_t;

   typedef struct packed {
      logic        valid;
      tctl_t       ctl;
      logic [63:0] pc, r1d, r2d, imm;
      logic [4:0]  rs1, rs2, rd;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic        stall;
   } obs_t;

   typedef struct packed {
      tctl_t       c;
      logic [63:0] imm;
      logic        u1, u2;
   } dec_t;

   obs_t oa, ob;

   always_comb begin
      oa.valid = ba.ex_valid;
      oa.ctl   = '{ba.ex_branch, ba.ex_memread, ba.ex_memwrite, ba.ex_memtoreg,
                   ba.ex_alusrc, ba.ex_regwrite, ba.ex_aluop, ba.ex_illegal};
      oa.pc = ba.ex_pc; oa.r1d = ba.ex_rs1_data; oa.r2d = ba.ex_rs2_data; oa.imm = ba.ex_imm;
      oa.rs1 = ba.ex_rs1; oa.rs2 = ba.ex_rs2; oa.rd = ba.ex_rd;
      oa.f3 = ba.ex_funct3; oa.f7 = ba.ex_funct7; oa.stall = ba.id_stall;
   end

   always_comb begin
      ob.valid = bb.ex_valid;
      ob.ctl   = '{bb.ex_branch, bb.ex_memread, bb.ex_memwrite, bb.ex_memtoreg,
                   bb.ex_alusrc, bb.ex_regwrite, bb.ex_aluop, bb.ex_illegal};
      ob.pc = {32'b0, bb.ex_pc}; ob.r1d = {32'b0, bb.ex_rs1_data};
      ob.r2d = {32'b0, bb.ex_rs2_data}; ob.imm = {32'b0, bb.ex_imm};
      ob.rs1 = bb.ex_rs1; ob.rs2 = bb.ex_rs2; ob.rd = bb.ex_rd;
      ob.f3 = bb.ex_funct3; ob.f7 = bb.ex_funct7; ob.stall = bb.id_stall;
   end

   task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", n, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [63:0] msk(input int c);
      return (c == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
   endfunction

   // Decode straight from the opcode table; is64/n16 select the configuration.
   function automatic dec_t decode(input logic [31:0] i, input bit is64, input bit n16);
      dec_t        d;
      logic [31:0] im;
      bit          urd;
      d = '0; im = 32'd0; d.u1 = 1'b1; urd = 1'b1;
      case (i[6:0])
         7'h33: begin d.c.regwrite = 1; d.c.aluop = 2; d.u2 = 1; end
         7'h13: begin d.c.alusrc = 1; d.c.regwrite = 1; d.c.aluop = 2; im = {{20{i[31]}}, i[31:20]}; end
         7'h03: begin d.c.memread = 1; d.c.memtoreg = 1; d.c.alusrc = 1; d.c.regwrite = 1;
                      im = {{20{i[31]}}, i[31:20]}; end
         7'h23: begin d.c.memwrite = 1; d.c.alusrc = 1; d.u2 = 1; urd = 0;
                      im = {{20{i[31]}}, i[31:25], i[11:7]}; end
         7'h63: begin d.c.branch = 1; d.c.aluop = 1; d.u2 = 1; urd = 0;
                      im = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0}; end
         7'h37, 7'h17: begin d.c.regwrite = 1; d.c.alusrc = 1; d.c.aluop = 3; d.u1 = 0;
                      im = {i[31:12], 12'b0}; end
         7'h6F: begin d.c.regwrite = 1; d.c.alusrc = 1; d.c.aluop = 3; d.u1 = 0;
                      im = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0}; end
         7'h67: begin d.c.regwrite = 1; d.c.alusrc = 1; d.c.aluop = 3; im = {{20{i[31]}}, i[31:20]}; end
         7'h3B: begin d.u2 = 1;
                      if (is64) begin d.c.regwrite = 1; d.c.aluop = 2; end else d.c.illegal = 1; end
         7'h1B: begin im = {{20{i[31]}}, i[31:20]};
                      if (is64) begin d.c.alusrc = 1; d.c.regwrite = 1; d.c.aluop = 2; end
                      else d.c.illegal = 1; end
         default: begin d.c.illegal = 1; urd = 0; end
      endcase
      if (n16 && ((d.u1 && i[19]) || (d.u2 && i[24]) || (urd && i[11]))) begin
         d.c = '0;
         d.c.illegal = 1;
      end
      d.imm = {{32{im[31]}}, im};
      return d;
   endfunction

   dec_t        dm [2];
   logic [63:0] rf_m [2][32];
   logic        mv [2];
   tctl_t       mc [2];
   logic [63:0] mpc [2], mr1d [2], mr2d [2], mimm [2];
   logic [4:0]  mrs1 [2], mrs2 [2], mrd [2];
   logic [2:0]  mf3 [2];
   logic [6:0]  mf7 [2];

   always_comb begin
      for (int c = 0; c < 2; c++) dm[c] = decode(s_inst, c == 0, c == 1);
   end

   function automatic logic [63:0] read_m(input int c, input logic [4:0] r);
      if (r == 5'd0 || (c == 1 && r[4])) return 64'd0;
      if (c == 0 && s_we && s_wrd == r) return s_wdata & msk(c);
      return rf_m[c][r];
   endfunction

   function automatic bit haz(input int c);
      return s_valid && mv[c] && mc[c].memread && mrd[c] != 5'd0 &&
             ((dm[c].u1 && s_inst[19:15] == mrd[c]) || (dm[c].u2 && s_inst[24:20] == mrd[c]));
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int c = 0; c < 2; c++) begin
            mv[c] <= 1'b0;
            mc[c] <= '0;
            for (int r = 0; r < 32; r++) rf_m[c][r] <= 64'd0;
         end
      end else begin
         for (int c = 0; c < 2; c++) begin
            if (s_flush) begin
               mv[c] <= 1'b0; mc[c] <= '0;
            end else if (!s_hold) begin
               if (s_valid && !haz(c)) begin
                  mv[c] <= 1'b1; mc[c] <= dm[c].c;
                  mpc[c] <= s_pc & msk(c); mimm[c] <= dm[c].imm & msk(c);
                  mr1d[c] <= read_m(c, s_inst[19:15]); mr2d[c] <= read_m(c, s_inst[24:20]);
                  mrs1[c] <= s_inst[19:15]; mrs2[c] <= s_inst[24:20]; mrd[c] <= s_inst[11:7];
                  mf3[c] <= s_inst[14:12]; mf7[c] <= s_inst[31:25];
               end else begin
                  mv[c] <= 1'b0; mc[c] <= '0;
               end
            end
            if (s_we && s_wrd != 5'd0 && !(c == 1 && s_wrd[4])) rf_m[c][s_wrd] <= s_wdata & msk(c);
         end
      end
   end

   task automatic cmp(input int c);
      obs_t  o;
      string t;
      o = (c == 0) ? oa : ob;
      t = (c == 0) ? "a" : "b";
      chk({t, ".ex_valid"}, 64'(o.valid), 64'(mv[c]));
      chk({t, ".ctl"}, 64'(o.ctl), 64'(mc[c]));
      if (mv[c]) begin
         chk({t, ".ex_pc"}, o.pc, mpc[c]);
         chk({t, ".ex_imm"}, o.imm, mimm[c]);
         chk({t, ".ex_rs1"}, 64'(o.rs1), 64'(mrs1[c]));
         chk({t, ".ex_rs2"}, 64'(o.rs2), 64'(mrs2[c]));
         chk({t, ".ex_rd"}, 64'(o.rd), 64'(mrd[c]));
         chk({t, ".ex_funct3"}, 64'(o.f3), 64'(mf3[c]));
         chk({t, ".ex_funct7"}, 64'(o.f7), 64'(mf7[c]));
         if (!mc[c].illegal) begin
            chk({t, ".ex_rs1_data"}, o.r1d, mr1d[c]);
            chk({t, ".ex_rs2_data"}, o.r2d, mr2d[c]);
         end
      end
   endtask

   always @(posedge clk) begin
      #1;
      for (int c = 0; c < 2; c++) cmp(c);
   end

   always @(negedge clk) begin
      #2;
      chk("a.id_stall", 64'(oa.stall), 64'(!reset && !s_flush && (s_hold || haz(0))));
      chk("b.id_stall", 64'(ob.stall), 64'(!reset && !s_flush && (s_hold || haz(1))));
   end

   // ---------------- directed stimulus ----------------
   task automatic drive(input logic v, input logic [31:0] inst, input logic [63:0] pc,
                        input logic h, input logic f, input logic we,
                        input logic [4:0] wr, input logic [63:0] wd);
      s_valid = v; s_inst = inst; s_pc = pc; s_hold = h; s_flush = f;
      s_we = we; s_wrd = wr; s_wdata = wd;
   endtask

   initial begin
      #20000;
      errors++;
      $display("FAIL timeout: got running expected finished");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      reset = 1'b1;
      drive(0, 32'h0, 64'h0, 1, 0, 0, 5'd0, 64'h0);
      @(negedge clk);
      chk("rst_valid_a", 64'(oa.valid), 64'd0);
      chk("rst_stall_a", 64'(oa.stall), 64'd0);
      chk("rst_pc_a", oa.pc, 64'd0);
      chk("rst_imm_b", ob.imm, 64'd0);
      reset = 1'b0;

      // x5 = 0x1234, then add x6,x5,x5
      drive(0, 32'h0, 64'h0, 0, 0, 1, 5'd5, 64'h1234); @(negedge clk);
      drive(1, 32'h00528333, 64'h100, 0, 0, 0, 5'd0, 64'h0); @(negedge clk);
      chk("add_valid_a", 64'(oa.valid), 64'd1);
      chk("add_rs1d_a", oa.r1d, 64'h1234);
      chk("add_rs2d_a", oa.r2d, 64'h1234);
      chk("add_regwrite_a", 64'(oa.ctl.regwrite), 64'd1);
      chk("add_aluop_a", 64'(oa.ctl.aluop), 64'd2);
      chk("add_rs1d_b", ob.r1d, 64'h1234);

      // addi x8,x7,-1 while x7 is written back
      drive(1, 32'hFFF38413, 64'h104, 0, 0, 1, 5'd7, 64'hAA); @(negedge clk);
      chk("byp_rs1d_a", oa.r1d, 64'hAA);
      chk("byp_imm_a", oa.imm, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("nobyp_rs1d_b", ob.r1d, 64'd0);
      chk("imm_b", ob.imm, 64'hFFFF_FFFF);

      // ld x9,0(x1) ; add x10,x9,x2 -> one bubble
      drive(1, 32'h0000B483, 64'h108, 0, 0, 0, 5'd0, 64'h0); @(negedge clk);
      chk("ld_memread_a", 64'(oa.ctl.memread), 64'd1);
      drive(1, 32'h00248533, 64'h10C, 0, 0, 0, 5'd0, 64'h0);
      #1 chk("lu_stall_a", 64'(oa.stall), 64'd1);
      chk("lu_stall_b", 64'(ob.stall), 64'd1);
      @(negedge clk);
      chk("lu_bubble_a", 64'(oa.valid), 64'd0);
      chk("lu_bubble_ctl_a", 64'(oa.ctl), 64'd0);
      #1 chk("lu_nostall_a", 64'(oa.stall), 64'd0);
      @(negedge clk);
      chk("lu_enter_a", 64'(oa.valid), 64'd1);
      chk("lu_rd_a", 64'(oa.rd), 64'd10);

      // ld then addi x10,x0,1 -> no stall
      drive(1, 32'h0000B483, 64'h110, 0, 0, 0, 5'd0, 64'h0); @(negedge clk);
      drive(1, 32'h00100513, 64'h114, 0, 0, 0, 5'd0, 64'h0);
      #1 chk("x0src_stall_a", 64'(oa.stall), 64'd0);
      @(negedge clk);
      chk("x0src_valid_a", 64'(oa.valid), 64'd1);

      // hold for 3 cycles, then flush during hold
      drive(1, 32'h00528333, 64'h200, 1, 0, 0, 5'd0, 64'h0);
      for (int k = 0; k < 3; k++) begin
         #1 chk("hold_stall_a", 64'(oa.stall), 64'd1);
         @(negedge clk);
         chk("hold_rd_a", 64'(oa.rd), 64'd10);
         chk("hold_imm_a", oa.imm, 64'd1);
         chk("hold_valid_a", 64'(oa.valid), 64'd1);
      end
      drive(1, 32'h00528333, 64'h200, 1, 1, 0, 5'd0, 64'h0);
      #1 chk("flush_stall_a", 64'(oa.stall), 64'd0);
      @(negedge clk);
      chk("flush_valid_a", 64'(oa.valid), 64'd0);
      chk("flush_valid_b", 64'(ob.valid), 64'd0);

      // illegal forms
      drive(1, 32'h0000007F, 64'h204, 0, 0, 0, 5'd0, 64'h0); @(negedge clk);
      chk("op7f_illegal_a", 64'(oa.ctl.illegal), 64'd1);
      chk("op7f_regwrite_a", 64'(oa.ctl.regwrite), 64'd0);
      drive(1, 32'h002081BB, 64'h208, 0, 0, 0, 5'd0, 64'h0); @(negedge clk);
      chk("addw_illegal_a", 64'(oa.ctl.illegal), 64'd0);
      chk("addw_regwrite_a", 64'(oa.ctl.regwrite), 64'd1);
      chk("addw_illegal_b", 64'(ob.ctl.illegal), 64'd1);
      chk("addw_regwrite_b", 64'(ob.ctl.regwrite), 64'd0);
      drive(1, 32'h002088B3, 64'h20C, 0, 0, 0, 5'd0, 64'h0); @(negedge clk);
      chk("x17_illegal_a", 64'(oa.ctl.illegal), 64'd0);
      chk("x17_illegal_b", 64'(ob.ctl.illegal), 64'd1);

      // x0 ignores writes
      drive(0, 32'h0, 64'h0, 0, 0, 1, 5'd0, 64'hFF); @(negedge clk);
      drive(1, 32'h00000333, 64'h210, 0, 0, 0, 5'd0, 64'h0); @(negedge clk);
      chk("x0_rs1d_a", oa.r1d, 64'd0);

      // immediate formats
      drive(1, 32'h0050A423, 64'h214, 0, 0, 0, 5'd0, 64'h0); @(negedge clk);
      chk("sw_imm_a", oa.imm, 64'd8);
      chk("sw_memwrite_a", 64'(oa.ctl.memwrite), 64'd1);
      drive(1, 32'hFE208EE3, 64'h218, 0, 0, 0, 5'd0, 64'h0); @(negedge clk);
      chk("beq_imm_a", oa.imm, 64'hFFFF_FFFF_FFFF_FFFC);
      drive(1, 32'h123452B7, 64'h21C, 0, 0, 0, 5'd0, 64'h0); @(negedge clk);
      chk("lui_imm_a", oa.imm, 64'h12345000);
      drive(1, 32'h008000EF, 64'h220, 0, 0, 0, 5'd0, 64'h0); @(negedge clk);
      chk("jal_imm_a", oa.imm, 64'd8);

      // asynchronous reset mid-stream
      drive(1, 32'h00528333, 64'h300, 0, 0, 0, 5'd0, 64'h0); @(negedge clk);
      reset = 1'b1;
      #1 chk("arst_valid_a", 64'(oa.valid), 64'd0);
      chk("arst_valid_b", 64'(ob.valid), 64'd0);
      #2 reset = 1'b0;
      @(negedge clk);
      chk("arst_x5_a", oa.r1d, 64'd0);
      chk("arst_x5_valid_a", 64'(oa.valid), 64'd1);

      drive(0, 32'h0, 64'h0, 0, 0, 0, 5'd0, 64'h0);
      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Parametrised pipelined instruction-decode stage for the riscvy cores; sits between fetch (IF) and execute (EX).
- Contains, internally:
  - instruction field split
  - NREG x XLEN register file with write-back bypass
  - immediate generator (I/S/B/U/J)
  - main control decode
  - load-use hazard detector
  - registered ID/EX pipeline boundary with valid, hold and flush
- Successor to the single-cycle combinational decode: adds pipelining, stalls, flush, RV32E/RV64 generality and illegal-instruction flagging.

Parameters:
- XLEN, 64, datapath width; 32 or 64 only.
- NREG, 32, architectural register count; 32 (RV32I/RV64I) or 16 (RV32E-style).
- BYPASS, 1, 1 = same-cycle write-back-to-read forwarding in the register file; 0 = none.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- if_valid  in  1  IF presents a valid instruction.
- if_inst  in  32  instruction word.
- if_pc  in  XLEN  PC of if_inst.
- ex_hold  in  1  EX back-pressure; freeze the ID/EX register.
- flush  in  1  squash the instruction in ID (taken branch or jump).
- wb_we  in  1  write-back enable.
- wb_rd  in  5  write-back destination.
- wb_data  in  XLEN  write-back data.
- id_stall  out  1  combinational; IF must hold PC and if_inst.
- ex_valid  out  1  ID/EX entry valid.
- ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  out  XLEN each  registered operands.
- ex_rs1, ex_rs2, ex_rd  out  5 each  registered register indices.
- ex_funct3  out  3  registered funct3.
- ex_funct7  out  7  registered funct7.
- ex_branch, ex_memread, ex_memwrite, ex_memtoreg, ex_alusrc, ex_regwrite  out  1 each  registered controls.
- ex_aluop  out  2  registered ALU op class.
- ex_illegal  out  1  registered illegal-instruction flag.

Behaviour:
- Reset (asynchronous):
  - all register-file entries = 0
  - every ex_* output = 0, including ex_valid = 0
  - id_stall = 0 while reset is asserted
  - mid-operation reset discards the in-flight entry.
- Register file:
  - x0 reads 0 and ignores writes.
  - Writes happen at the clk edge when wb_we is set and wb_rd is nonzero and below NREG.
  - When BYPASS=1 and wb_we is set and wb_rd equals rs (nonzero), the read returns wb_data in the same cycle.
  - When BYPASS=0, the read returns the old value.
- Immediates: sign-extended to XLEN from inst[31].
  - I: inst[31:20]
  - S: {inst[31:25], inst[11:7]}
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}
  - U: {inst[31:12], 12'b0}
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}
  - R-type: 0.
- Control decode by opcode (flags listed are 1, all others 0):
  - 0110011 R: regwrite; aluop=10.
  - 0010011 I-alu: alusrc, regwrite; aluop=10.
  - 0000011 load: memread, memtoreg, alusrc, regwrite; aluop=00.
  - 0100011 store: memwrite, alusrc; aluop=00.
  - 1100011 branch: branch; aluop=01.
  - 0110111 LUI, 0010111 AUIPC, 1101111 JAL, 1100111 JALR: regwrite, alusrc; aluop=11.
  - 0111011 and 0011011 (W forms): decoded like R and I-alu only when XLEN=64; illegal otherwise.
  - Any other opcode: illegal=1, all controls 0.
  - When NREG=16, any used rs1/rs2/rd index with bit 4 set gives illegal=1 and all controls 0.
- Load-use hazard:
  - Condition: ex_valid, ex_memread and ex_rd != 0 all hold, and ex_rd equals a source the ID instruction uses (rs1 for all except LUI/AUIPC/JAL; rs2 for R, store, branch and R-W).
  - On hazard: id_stall=1 and a bubble is written (ex_valid=0, all controls 0).
  - Exactly one bubble per load-use pair; the next cycle proceeds.
- ID/EX update priority per clk edge:
  1. flush: ex_valid=0 and controls 0, regardless of ex_hold or hazard.
  2. ex_hold: all ex_* keep their values; id_stall=1.
  3. hazard: bubble as above.
  4. if_valid: capture the decoded instruction, ex_valid=1.
  5. otherwise: ex_valid=0.
- id_stall = (ex_hold or hazard) and not flush.

Test Plan:
- Reset then wb writes x5=0x1234; issue `add x6,x5,x5` (0x00528333) -> next cycle ex_valid=1, ex_rs1_data=ex_rs2_data=0x1234, ex_regwrite=1, ex_aluop=10.
- Same cycle, wb_we x7=0xAA while `addi x8,x7,-1` (0xFFF38413) is in ID -> BYPASS=1: ex_rs1_data=0xAA and ex_imm=all-ones; BYPASS=0: ex_rs1_data=0.
- `ld x9,0(x1)` then `add x10,x9,x2` -> one cycle with id_stall=1 and ex_valid=0; the add enters the following cycle. `addi x10,x0,1` after the load -> no stall.
- ex_hold high for 3 cycles -> ex_* unchanged and id_stall=1 throughout; assert flush during hold -> ex_valid=0 next edge.
- Opcode 0x7F, or XLEN=32 with `addw` -> ex_illegal=1, ex_regwrite=0; with NREG=16, `add x17,x1,x2` -> ex_illegal=1.
- Write x0=0xFF, then read x0 -> 0; pulse reset mid-stream -> ex_valid=0 immediately (asynchronous) and x5 reads 0 after release.
